// File: rtl/sixteen_bit_divider_pkg.sv
// Shared constants and state encoding for the iterative restoring divider.
// Consumers: sixteen_bit_divider_if, sixteen_bit_divider.
package div_pkg;

    localparam int DIV_WIDTH = 16;
    localparam int DIV_CNT_W = $clog2(DIV_WIDTH + 1);

    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_BUSY,
        DIV_DONE
    } div_state_t;

endpackage

// File: rtl/sixteen_bit_divider_if.sv
// Request/result bundle between the execute stage (master) and the divider (slave).
interface sixteen_bit_divider_if
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
);

    logic             start;
    logic             op_signed;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, op_signed, in1, in2,
        input  ready, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, op_signed, in1, in2,
        output ready, done, quotient, remainder, div_by_zero
    );

endinterface

// File: rtl/sixteen_bit_divider_restore_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract the divisor.
module div_restore_step #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             dvd_msb,
    input  logic [WIDTH-1:0] dvs,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // The trial subtract is one bit wider than the operands; its borrow is the inverted quotient bit.
    always_comb begin
        shifted = {rem_in, dvd_msb};
        diff    = shifted - {1'b0, dvs};
        q_bit   = ~diff[WIDTH];
        rem_out = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/sixteen_bit_divider.sv
// Iterative restoring divider, one quotient bit per clock, RISC-V M-extension corner results.
// Define SIGNED_DIV_EN to enable signed operation via bus.op_signed.
module sixteen_bit_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input logic                  clk,
    input logic                  rst_n,
    sixteen_bit_divider_if.slave bus
);

    localparam int               CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    div_state_t       state, state_nxt;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] dvd, dvs, rem;
    logic             zero_q;
    logic             ready, done;
    logic             accept, last_iter, in2_zero;
    logic [WIDTH-1:0] mag1, mag2;
    logic [WIDTH-1:0] rem_out, q_next, q_fix, r_fix;
    logic             q_bit;
    logic [WIDTH-1:0] quotient_q, remainder_q;
    logic             dbz_q;

    assign accept    = ready & bus.start;
    assign last_iter = (count == LAST);
    assign in2_zero  = (bus.in2 == '0);
    assign q_next    = {dvd[WIDTH-2:0], q_bit};

`ifdef SIGNED_DIV_EN
    logic neg1, neg2, neg_q, neg_r;

    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] x);
        return ~x + WIDTH'(1);
    endfunction

    always_comb begin
        neg1 = bus.op_signed & bus.in1[WIDTH-1];
        neg2 = bus.op_signed & bus.in2[WIDTH-1];
        mag1 = neg1 ? negate(bus.in1) : bus.in1;
        mag2 = neg2 ? negate(bus.in2) : bus.in2;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (accept) begin
            neg_q <= neg1 ^ neg2;
            neg_r <= neg1;
        end
    end

    // Most-negative / -1 needs no special case: magnitude 2^(WIDTH-1) negates to itself.
    assign q_fix = neg_q ? negate(q_next) : q_next;
    assign r_fix = neg_r ? negate(rem_out) : rem_out;
`else
    logic unused_op_signed;

    assign unused_op_signed = bus.op_signed;
    assign mag1  = bus.in1;
    assign mag2  = bus.in2;
    assign q_fix = q_next;
    assign r_fix = rem_out;
`endif

    div_restore_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (rem),
        .dvd_msb (dvd[WIDTH-1]),
        .dvs     (dvs),
        .rem_out (rem_out),
        .q_bit   (q_bit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= DIV_IDLE;
        else        state <= state_nxt;
    end

    // A zero divisor spends exactly one cycle in BUSY, so its done lands one edge after acceptance.
    always_comb begin
        state_nxt = state;
        unique case (state)
            DIV_IDLE: if (bus.start) state_nxt = DIV_BUSY;
            DIV_BUSY: if (zero_q || last_iter) state_nxt = DIV_DONE;
            DIV_DONE: state_nxt = bus.start ? DIV_BUSY : DIV_IDLE;
            default:  state_nxt = DIV_IDLE;
        endcase
    end

    always_comb begin
        ready = (state != DIV_BUSY);
        done  = (state == DIV_DONE);
    end

    // For a zero divisor the raw dividend is parked in dvd so it can be returned as the remainder.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dvd         <= '0;
            dvs         <= '0;
            rem         <= '0;
            count       <= '0;
            zero_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else if (accept) begin
            dvd    <= in2_zero ? bus.in1 : mag1;
            dvs    <= mag2;
            rem    <= '0;
            count  <= '0;
            zero_q <= in2_zero;
        end else if (state == DIV_BUSY) begin
            if (zero_q) begin
                quotient_q  <= '1;
                remainder_q <= dvd;
                dbz_q       <= 1'b1;
            end else begin
                rem   <= rem_out;
                dvd   <= q_next;
                count <= count + CNT_W'(1);
                if (last_iter) begin
                    quotient_q  <= q_fix;
                    remainder_q <= r_fix;
                    dbz_q       <= 1'b0;
                end
            end
        end
    end

    assign bus.ready       = ready;
    assign bus.done        = done;
    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_sixteen_bit_divider.sv
// Self-checking bench for sixteen_bit_divider: vector table, scoreboard queue, handshake corner cases.
module tb_sixteen_bit_divider;

    typedef struct {
        logic [15:0] q;
        logic [15:0] r;
        logic        dbz;
    } exp_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        sgn;
        logic [15:0] q;
        logic [15:0] r;
        logic        dbz;
        int          lat;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    sixteen_bit_divider_if #(.WIDTH(16)) bus ();

    sixteen_bit_divider #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    exp_t sb[$];
    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [15:0] a, input logic [15:0] b, input logic sgn,
                                input logic [15:0] q, input logic [15:0] r, input logic dbz);
        vec_t v;
        v.a = a; v.b = b; v.sgn = sgn; v.q = q; v.r = r; v.dbz = dbz;
        v.lat = dbz ? 2 : 17;
        return v;
    endfunction

    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.done === 1'b1) begin
            exp_t e;
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'(bus.done), 32'(0));
            end else begin
                e = sb.pop_front();
                chk("quotient", 32'(bus.quotient), 32'(e.q));
                chk("remainder", 32'(bus.remainder), 32'(e.r));
                chk("div_by_zero", 32'(bus.div_by_zero), 32'(e.dbz));
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic sgn,
                         input exp_t e, input bit push);
        int n;
        n = 0;
        while (bus.ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        chk("ready_before_start", 32'(bus.ready), 32'(1));
        bus.in1       = a;
        bus.in2       = b;
        bus.op_signed = sgn;
        bus.start     = 1'b1;
        if (push) sb.push_back(e);
        tick();
        bus.start = 1'b0;
    endtask

    // Called right after the accepting edge; returns once done is seen or the budget expires.
    task automatic wait_done(input int lat);
        int n;
        n = 1;
        if (lat > 2) chk("ready_low_busy", 32'(bus.ready), 32'(0));
        while (bus.done !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk("latency", 32'(n), 32'(lat));
    endtask

    task automatic run_vec(input vec_t v);
        exp_t e;
        e.q = v.q; e.r = v.r; e.dbz = v.dbz;
        issue(v.a, v.b, v.sgn, e, 1'b1);
        wait_done(v.lat);
        tick();
        chk("done_single_cycle", 32'(bus.done), 32'(0));
        chk("quotient_held", 32'(bus.quotient), 32'(v.q));
    endtask

    initial begin
        exp_t e;
        int   n, ndone, first;
        logic [15:0] a, b;

        vecs.push_back(mk(16'd100,  16'd7,    1'b0, 16'h000E, 16'h0002, 1'b0));
        vecs.push_back(mk(16'h04D2, 16'h0000, 1'b0, 16'hFFFF, 16'h04D2, 1'b1));
        vecs.push_back(mk(16'h0000, 16'h0003, 1'b0, 16'h0000, 16'h0000, 1'b0));
        vecs.push_back(mk(16'hFFFF, 16'hFFFF, 1'b0, 16'h0001, 16'h0000, 1'b0));
        vecs.push_back(mk(16'h1234, 16'h0100, 1'b0, 16'h0012, 16'h0034, 1'b0));
        vecs.push_back(mk(16'h8000, 16'h0003, 1'b0, 16'h2AAA, 16'h0002, 1'b0));
        vecs.push_back(mk(16'h0003, 16'h0009, 1'b0, 16'h0000, 16'h0003, 1'b0));
        vecs.push_back(mk(16'd7,    16'd2,    1'b0, 16'h0003, 16'h0001, 1'b0));
`ifdef SIGNED_DIV_EN
        vecs.push_back(mk(16'hFFF9, 16'h0002, 1'b1, 16'hFFFD, 16'hFFFF, 1'b0));
        vecs.push_back(mk(16'h8000, 16'hFFFF, 1'b1, 16'h8000, 16'h0000, 1'b0));
        vecs.push_back(mk(16'h0007, 16'hFFFE, 1'b1, 16'hFFFD, 16'h0001, 1'b0));
        vecs.push_back(mk(16'hFFF9, 16'hFFFE, 1'b1, 16'h0003, 16'hFFFF, 1'b0));
        vecs.push_back(mk(16'hFFF9, 16'h0000, 1'b1, 16'hFFFF, 16'hFFF9, 1'b1));
`else
        vecs.push_back(mk(16'hFFF9, 16'h0002, 1'b1, 16'h7FFC, 16'h0001, 1'b0));
        vecs.push_back(mk(16'h8000, 16'hFFFF, 1'b1, 16'h0000, 16'h8000, 1'b0));
`endif

        bus.start = 1'b0; bus.op_signed = 1'b0; bus.in1 = '0; bus.in2 = '0;
        rst_n = 1'b0;
        repeat (3) tick();
        chk("rst_ready", 32'(bus.ready), 32'(1));
        chk("rst_done", 32'(bus.done), 32'(0));
        chk("rst_quotient", 32'(bus.quotient), 32'(0));
        chk("rst_remainder", 32'(bus.remainder), 32'(0));
        chk("rst_dbz", 32'(bus.div_by_zero), 32'(0));
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i]);

        // Back-to-back: second request issued in the done cycle of the first.
        e.q = 16'hFFFF; e.r = 16'h0000; e.dbz = 1'b0;
        issue(16'hFFFF, 16'h0001, 1'b0, e, 1'b1);
        wait_done(17);
        chk("ready_in_done", 32'(bus.ready), 32'(1));
        bus.in1 = 16'h0005; bus.in2 = 16'h0009; bus.start = 1'b1;
        e.q = 16'h0000; e.r = 16'h0005; e.dbz = 1'b0;
        sb.push_back(e);
        tick();
        bus.start = 1'b0;
        wait_done(17);
        tick();

        // start with new operands during BUSY must be ignored.
        e.q = 16'h000E; e.r = 16'h0002; e.dbz = 1'b0;
        issue(16'd100, 16'd7, 1'b0, e, 1'b1);
        n = 1;
        repeat (4) begin tick(); n++; end
        chk("ready_low_mid_busy", 32'(bus.ready), 32'(0));
        bus.in1 = 16'h0FFF; bus.in2 = 16'h0003; bus.start = 1'b1;
        tick(); n++;
        bus.start = 1'b0;
        ndone = 0; first = 0;
        while (n < 40) begin
            if (bus.done === 1'b1) begin
                ndone++;
                if (first == 0) first = n;
            end
            tick(); n++;
        end
        chk("ignored_start_latency", 32'(first), 32'(17));
        chk("ignored_start_done_count", 32'(ndone), 32'(1));

        // Reset mid-operation: no done, outputs back to reset values.
        issue(16'h1234, 16'h0056, 1'b0, e, 1'b0);
        repeat (7) tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_ready", 32'(bus.ready), 32'(1));
        chk("midrst_done", 32'(bus.done), 32'(0));
        chk("midrst_quotient", 32'(bus.quotient), 32'(0));
        chk("midrst_remainder", 32'(bus.remainder), 32'(0));
        chk("midrst_dbz", 32'(bus.div_by_zero), 32'(0));
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (20) tick();
        run_vec(mk(16'd50, 16'd5, 1'b0, 16'h000A, 16'h0000, 1'b0));

        // Randomised unsigned operands against the language's own / and %.
        for (int i = 0; i < 8; i++) begin
            a = 16'($urandom_range(0, 65535));
            b = (i % 2 == 0) ? 16'($urandom_range(1, 255)) : 16'($urandom_range(1, 65535));
            run_vec(mk(a, b, 1'b0, a / b, a % b, 1'b0));
        end

        repeat (3) tick();
        chk("scoreboard_empty", 32'(sb.size()), 32'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
